// File: rtl/menu_pkg.sv
// Shared definitions for the menu controller: key codes, FSM states and menu rows.
package menu_pkg;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;

    localparam logic ROW_PLAYERS = 1'b0;
    localparam logic ROW_START   = 1'b1;

    localparam logic [3:0] LEVEL_BLACK = 4'd0;
    localparam logic [3:0] LEVEL_FULL  = 4'd15;

    typedef enum logic [2:0] {
        MENU          = 3'd0,
        FADE_OUT      = 3'd1,
        FADE_IN       = 3'd2,
        GAME          = 3'd3,
        FADE_OUT_MENU = 3'd4,
        FADE_IN_MENU  = 3'd5
    } menu_state_t;

    // True for the four states in which the fade sequencer is stepping.
    function automatic logic is_fade_state(input menu_state_t s);
        return (s == FADE_OUT) || (s == FADE_IN) ||
               (s == FADE_OUT_MENU) || (s == FADE_IN_MENU);
    endfunction

    // True for the states that brighten the screen.
    function automatic logic is_fade_in_state(input menu_state_t s);
        return (s == FADE_IN) || (s == FADE_IN_MENU);
    endfunction

endpackage

// File: rtl/menu_controller_fade.sv
// Frame-timed brightness stepper: holds each level for FADE_FRAMES frame_start
// pulses and reports done when a step would pass the end of the range.
module fade_sequencer
    import menu_pkg::*;
#(
    parameter int FADE_FRAMES = 2
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       i_start,
    input  logic       i_active,
    input  logic       i_direction,
    input  logic       i_frame_start,
    output logic [3:0] o_level,
    output logic       o_done
);

    localparam int              CW        = $clog2(FADE_FRAMES + 1);
    localparam logic [CW-1:0]   LAST_STEP = CW'(FADE_FRAMES - 1);

    logic [CW-1:0] r_count;
    logic [3:0]    r_level;
    logic          w_step;
    logic          w_at_end;

    // A step happens on the last held frame; the end of range depends on direction.
    always_comb begin
        w_step   = i_active && i_frame_start && (r_count == LAST_STEP);
        w_at_end = i_direction ? (r_level == LEVEL_FULL) : (r_level == LEVEL_BLACK);
        o_done   = w_step && w_at_end;
    end

    // Frame counter and brightness level; level is held (not wrapped) at the end of range.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_count <= '0;
            r_level <= LEVEL_FULL;
        end else if (i_start) begin
            r_count <= '0;
        end else if (i_active && i_frame_start) begin
            if (r_count == LAST_STEP) begin
                r_count <= '0;
                if (!w_at_end) begin
                    r_level <= i_direction ? (r_level + 4'd1) : (r_level - 4'd1);
                end
            end else begin
                r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/menu_controller.sv
// Menu screen sequencer: keyboard edge detection, cursor/player-count config,
// and the fade transitions between the menu image and the game map.
module menu_controller
    import menu_pkg::*;
#(
    parameter int NUM_ITEMS   = 2,
    parameter int MIN_PLAYERS = 2,
    parameter int MAX_PLAYERS = 6,
    parameter int FADE_FRAMES = 2
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic [7:0] keycode,
    input  logic       frame_start,
    output logic       cursor_row,
    output logic [2:0] num_players,
    output logic [3:0] fade_level,
    output logic       show_game,
    output logic       start_game,
    output logic       busy
);

    localparam logic [2:0] MIN_P    = 3'(MIN_PLAYERS);
    localparam logic [2:0] MAX_P    = 3'(MAX_PLAYERS);
    localparam logic       LAST_ROW = 1'(NUM_ITEMS - 1);

    menu_state_t r_state, w_state_next;
    logic        r_cursor_row, w_cursor_next;
    logic [2:0]  r_players, w_players_next;
    logic        r_show_game, w_show_next;
    logic        r_start_game, w_start_next;
    logic        r_busy, w_busy_next;
    logic [7:0]  r_prev_key;
    logic        w_press;
    logic        w_fade_start;
    logic        w_fade_done;
    logic [3:0]  w_fade_level;

    assign w_press = (keycode != KEY_NONE) && (r_prev_key == KEY_NONE);

    fade_sequencer #(
        .FADE_FRAMES (FADE_FRAMES)
    ) u_fade (
        .vga_clk       (vga_clk),
        .reset_n       (reset_n),
        .i_start       (w_fade_start),
        .i_active      (is_fade_state(r_state)),
        .i_direction   (is_fade_in_state(r_state)),
        .i_frame_start (frame_start),
        .o_level       (w_fade_level),
        .o_done        (w_fade_done)
    );

    // Next-state and next-output decode; keys only act in MENU/GAME, frames only in fades.
    always_comb begin
        w_state_next   = r_state;
        w_cursor_next  = r_cursor_row;
        w_players_next = r_players;
        w_show_next    = r_show_game;
        w_start_next   = 1'b0;
        w_busy_next    = r_busy;
        w_fade_start   = 1'b0;
        case (r_state)
            MENU: begin
                if (w_press) begin
                    case (keycode)
                        KEY_UP:    w_cursor_next = (r_cursor_row == ROW_PLAYERS) ? r_cursor_row
                                                                                 : r_cursor_row - 1'b1;
                        KEY_DOWN:  w_cursor_next = (r_cursor_row == LAST_ROW) ? r_cursor_row
                                                                              : r_cursor_row + 1'b1;
                        KEY_LEFT:  w_players_next = ((r_cursor_row == ROW_PLAYERS) && (r_players > MIN_P))
                                                    ? r_players - 3'd1 : r_players;
                        KEY_RIGHT: w_players_next = ((r_cursor_row == ROW_PLAYERS) && (r_players < MAX_P))
                                                    ? r_players + 3'd1 : r_players;
                        KEY_ENTER: begin
                            if (r_cursor_row == ROW_START) begin
                                w_state_next = FADE_OUT;
                                w_busy_next  = 1'b1;
                                w_fade_start = 1'b1;
                            end else begin
                                w_state_next = r_state;
                            end
                        end
                        default: w_state_next = r_state;
                    endcase
                end else begin
                    w_state_next = r_state;
                end
            end
            FADE_OUT: begin
                if (w_fade_done) begin
                    w_state_next = FADE_IN;
                    w_show_next  = 1'b1;
                    w_start_next = 1'b1;
                end else begin
                    w_state_next = r_state;
                end
            end
            FADE_IN: begin
                if (w_fade_done) begin
                    w_state_next = GAME;
                    w_busy_next  = 1'b0;
                end else begin
                    w_state_next = r_state;
                end
            end
            GAME: begin
                if (w_press && (keycode == KEY_ESC)) begin
                    w_state_next = FADE_OUT_MENU;
                    w_busy_next  = 1'b1;
                    w_fade_start = 1'b1;
                end else begin
                    w_state_next = r_state;
                end
            end
            FADE_OUT_MENU: begin
                if (w_fade_done) begin
                    w_state_next = FADE_IN_MENU;
                    w_show_next  = 1'b0;
                end else begin
                    w_state_next = r_state;
                end
            end
            FADE_IN_MENU: begin
                if (w_fade_done) begin
                    w_state_next = MENU;
                    w_busy_next  = 1'b0;
                end else begin
                    w_state_next = r_state;
                end
            end
            default: begin
                w_state_next = MENU;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    // State, configuration and output registers plus the key-edge history.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_state      <= MENU;
            r_cursor_row <= ROW_PLAYERS;
            r_players    <= MIN_P;
            r_show_game  <= 1'b0;
            r_start_game <= 1'b0;
            r_busy       <= 1'b0;
            r_prev_key   <= KEY_NONE;
        end else begin
            r_state      <= w_state_next;
            r_cursor_row <= w_cursor_next;
            r_players    <= w_players_next;
            r_show_game  <= w_show_next;
            r_start_game <= w_start_next;
            r_busy       <= w_busy_next;
            r_prev_key   <= keycode;
        end
    end

    assign cursor_row  = r_cursor_row;
    assign num_players = r_players;
    assign fade_level  = w_fade_level;
    assign show_game   = r_show_game;
    assign start_game  = r_start_game;
    assign busy        = r_busy;

endmodule
